// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter: round-robin sharing of one 8-bit logical barrel shifter between two requesters
module barrel_shifter (
  input  logic [7:0] data,
  input  logic [2:0] shamt,
  input  logic       dir,
  output logic [7:0] result
);
  logic [7:0] s1, s2;
  always_comb begin
    s1 = shamt[0] ? (dir ? {data[6:0], 1'b0} : {1'b0, data[7:1]}) : data;
    s2 = shamt[1] ? (dir ? {s1[5:0], 2'b0} : {2'b0, s1[7:2]}) : s1;
    result = shamt[2] ? (dir ? {s2[3:0], 4'b0} : {4'b0, s2[7:4]}) : s2;
  end
endmodule

module barrel_shift_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [2:0] shamt0,
  input  logic [2:0] shamt1,
  input  logic       dir0,
  input  logic       dir1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_id,
  input  logic       out_ready
);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  state_t state;
  logic last_id, cur_id, op_dir, sel;
  logic [7:0] op_data, shifted;
  logic [2:0] op_shamt;
  // on contention the requester that did not win last time goes first
  assign sel = (req0 & req1) ? ~last_id : req1;
  barrel_shifter u_shifter (
    .data(op_data),
    .shamt(op_shamt),
    .dir(op_dir),
    .result(shifted)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      out_valid <= 1'b0;
      out_data <= 8'h00;
      out_id <= 1'b0;
      last_id <= 1'b1;
      cur_id <= 1'b0;
      op_data <= 8'h00;
      op_shamt <= 3'd0;
      op_dir <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: if (req0 | req1) begin
          op_data <= sel ? in1 : in0;
          op_shamt <= sel ? shamt1 : shamt0;
          op_dir <= sel ? dir1 : dir0;
          cur_id <= sel;
          last_id <= sel;
          gnt0 <= ~sel;
          gnt1 <= sel;
          state <= SHIFT;
        end
        SHIFT: begin
          out_data <= shifted;
          out_id <= cur_id;
          out_valid <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// tb_barrel_shift_arbiter: directed and randomized checks against a transaction-level model
module tb_barrel_shift_arbiter;
  logic clk = 0, rst;
  logic req0 = 0, req1 = 0, dir0 = 0, dir1 = 0, out_ready = 1;
  logic [7:0] in0 = 0, in1 = 0;
  logic [2:0] shamt0 = 0, shamt1 = 0;
  logic gnt0, gnt1, out_valid, out_id;
  logic [7:0] out_data;
  int checks = 0, failures = 0;

  barrel_shift_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .in0(in0), .in1(in1),
    .shamt0(shamt0), .shamt1(shamt1), .dir0(dir0), .dir1(dir1),
    .gnt0(gnt0), .gnt1(gnt1), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic int mshift(int v, int s, bit d);
    return d ? (v * (1 << s)) % 256 : v / (1 << s);
  endfunction

  function automatic bit pick(bit r0, bit r1, bit last);
    return (r0 && r1) ? !last : r1;
  endfunction

  // model: one transaction at a time; result computed when the request wins
  bit m_gnt0, m_gnt1, m_valid, m_id, m_last, m_busy, m_win;
  int m_data, m_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_gnt0 <= 0; m_gnt1 <= 0; m_valid <= 0; m_data <= 0; m_id <= 0;
      m_last <= 1; m_busy <= 0; m_win <= 0; m_res <= 0;
    end else begin
      m_gnt0 <= 0;
      m_gnt1 <= 0;
      if (m_busy) begin
        m_valid <= 1; m_data <= m_res; m_id <= m_win; m_busy <= 0;
      end else if (m_valid) begin
        if (out_ready) m_valid <= 0;
      end else if (req0 || req1) begin
        m_win <= pick(req0, req1, m_last);
        m_last <= pick(req0, req1, m_last);
        m_res <= pick(req0, req1, m_last) ? mshift(in1, shamt1, dir1) : mshift(in0, shamt0, dir0);
        m_gnt0 <= !pick(req0, req1, m_last);
        m_gnt1 <= pick(req0, req1, m_last);
        m_busy <= 1;
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("gnt0", gnt0, m_gnt0);
    chk("gnt1", gnt1, m_gnt1);
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_id", out_id, m_id);
    chk("gnt_exclusive", gnt0 & gnt1, 0);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_gnt(output int who, output int n);
    who = -1;
    for (n = 1; n <= 30; n++) begin
      tick;
      if (gnt0) begin who = 0; return; end
      if (gnt1) begin who = 1; return; end
    end
    checks++;
    failures++;
    $display("FAIL gnt_timeout actual=none required=grant within 30 cycles");
  endtask

  task automatic set_req(int r, int d, int s, bit dr);
    if (r == 0) begin req0 = 1; in0 = 8'(d); shamt0 = 3'(s); dir0 = dr; end
    else begin req1 = 1; in1 = 8'(d); shamt1 = 3'(s); dir1 = dr; end
  endtask

  task automatic do_op(int r, int d, int s, bit dr, int exp);
    int who, n;
    set_req(r, d, s, dr);
    wait_gnt(who, n);
    chk("op_gnt_who", who, r);
    chk("op_gnt_latency", n, 1);
    req0 = 0; req1 = 0;
    tick;
    chk("op_valid", out_valid, 1);
    chk("op_data", out_data, exp);
    chk("op_id", out_id, r);
    tick;
  endtask

  task automatic do_reset;
    tick; #2 rst = 1;
    tick; #2 rst = 0;
  endtask

  task automatic reset_mid(int phase);
    int who, n;
    out_ready = 0;
    set_req(0, $urandom_range(1, 255), $urandom_range(0, 7), 1);
    wait_gnt(who, n);
    req0 = 0;
    if (phase == 1) begin tick; chk("mid_hold_valid", out_valid, 1); end
    #2 rst = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_gnt", gnt0 | gnt1, 0);
    tick; #2 rst = 0;
    tick;
    chk("post_rst_gnt", gnt0 | gnt1, 0);
    set_req(0, 8'h11, 1, 1);
    set_req(1, 8'h22, 1, 0);
    wait_gnt(who, n);
    chk("post_rst_first", who, 0);
    req0 = 0; req1 = 0; out_ready = 1;
    tick; tick;
  endtask

  initial begin
    int who, n, hold_d, hold_i;
    rst = 1;
    tick; tick;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_id", out_id, 0);
    #2 rst = 0;
    repeat (3) begin tick; chk("idle_no_gnt", gnt0 | gnt1, 0); end
    do_op(0, 8'hB3, 3, 1, 8'h98);
    do_op(1, 8'hB3, 3, 0, 8'h16);
    do_op(1, 8'hB3, 0, 0, 8'hB3);
    do_op(0, 8'hB3, 0, 1, 8'hB3);
    do_op(1, 8'hB3, 7, 0, 8'h01);
    do_op(0, 8'hFF, 7, 1, 8'h80);
    // fairness under continuous contention
    do_reset;
    set_req(0, $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 1));
    set_req(1, $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 1));
    for (int k = 0; k < 8; k++) begin
      wait_gnt(who, n);
      chk("rr_order", who, k % 2);
      if (who == 0) req0 = 0; else req1 = 0;
      tick;
      chk("rr_out_id", out_id, k % 2);
      set_req(who, $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 1));
    end
    req0 = 0; req1 = 0;
    tick; tick; tick;
    // backpressure
    out_ready = 0;
    set_req(0, 8'h5A, 2, 1);
    wait_gnt(who, n);
    req0 = 0;
    tick;
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 8'h68);
    hold_d = out_data;
    hold_i = out_id;
    set_req(1, 8'hC3, 1, 0);
    repeat (5) begin
      tick;
      chk("bp_no_gnt1", gnt1, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, hold_d);
      chk("bp_hold_id", out_id, hold_i);
    end
    out_ready = 1;
    tick;
    chk("bp_accept_valid", out_valid, 0);
    chk("bp_accept_gnt1", gnt1, 0);
    tick;
    chk("bp_late_gnt1", gnt1, 1);
    req1 = 0;
    tick; tick; tick;
    reset_mid(0);
    reset_mid(1);
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick;
      out_ready = ($urandom_range(0, 1) == 1);
      if (gnt0) req0 = 0;
      else if (!req0 && $urandom_range(0, 3) == 0) set_req(0, $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 1));
      else if (req0 && $urandom_range(0, 15) == 0) req0 = 0;
      if (gnt1) req1 = 0;
      else if (!req1 && $urandom_range(0, 3) == 0) set_req(1, $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 1));
      else if (req1 && $urandom_range(0, 15) == 0) req1 = 0;
      if (c == 1500) begin #2 rst = 1; #3; #2 rst = 0; end
    end
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/barrel_shift_arbiter.md
# barrel_shift_arbiter

Round-robin arbiter and sequencer that shares one 8-bit bidirectional logical barrel shifter between two requesters. It accepts a shift request from requester 0 or 1 over a req/gnt handshake and latches that requester's operands into operand registers that drive the shifter. It then registers the shifted result and presents it with the winner's ID on a valid/ready output port. It sits between the two shift-using clients and the single `barrel_shifter` instance, which it instantiates internally.

## Interface
- No parameters; data width fixed at 8, shift amount at 3 bits.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req0`, `req1` input 1 each: request from requester 0 / 1.
- `in0`, `in1` input 8 each: operand to shift.
- `shamt0`, `shamt1` input 3 each: shift amount, 0–7.
- `dir0`, `dir1` input 1 each: 1 = logical left, 0 = logical right; zero-fill both ways.
- `gnt0`, `gnt1` output 1 each: one-cycle registered grant pulse; operands captured.
- `out_valid` output 1: result available.
- `out_data` output 8: shifted result.
- `out_id` output 1: requester that owns `out_data`.
- `out_ready` input 1: consumer accepts result when high with `out_valid`.

## Operation
- FSM states: IDLE, SHIFT, HOLD. Reset state IDLE.
- IDLE:
  - If neither request is high, remain in IDLE.
  - If exactly one request is high, select it.
  - If both are high, select the requester other than `last_id`.
  - On the selecting edge: latch the selected `in/shamt/dir` into operand registers, set `cur_id`, update `last_id`, pulse the matching `gnt` high for the next cycle, and go to SHIFT.
- SHIFT:
  - Operand registers drive the shifter.
  - On the edge: `out_data` <= shifter output, `out_id` <= `cur_id`, `out_valid` <= 1, go to HOLD.
  - `gnt` returns to 0.
- HOLD:
  - `out_valid`, `out_data` and `out_id` are held stable.
  - If `out_ready` is high on an edge: `out_valid` <= 0, go to IDLE.
  - Otherwise remain in HOLD indefinitely.
- Arithmetic:
  - Left: `out = (in << shamt)[7:0]`.
  - Right: `out = in >> shamt`.
  - `shamt` = 0 passes the operand through unchanged in both directions.
- Round-robin: `last_id` resets to 1, so requester 0 wins the first contention.
- Requester rules:
  - Hold `req` and operands stable until the cycle `gnt` is seen.
  - Deassert `req` in the `gnt` cycle. A `req` still high when the FSM next samples in IDLE is treated as a new request.
  - Dropping `req` before grant withdraws the request with no side effects.
- Requests arriving in SHIFT or HOLD are ignored (not queued). They are evaluated on return to IDLE.
- Only one operation is in flight at a time. A new request is never accepted while a result is unconsumed.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - `gnt0` = `gnt1` = 0.
  - `out_valid` = 0, `out_data` = 8'h00, `out_id` = 0.
  - `last_id` = 1; operand registers = 0.
- Request sampled high at edge E in IDLE:
  - `gnt` is high during cycle E..E+1.
  - `out_valid` rises after edge E+1.
- Minimum occupancy is 3 cycles per operation with `out_ready` tied high. The next request is sampled at edge E+3.
- `gnt0` and `gnt1` are never high together; each pulse lasts exactly one cycle.
- `out_data` changes only on the SHIFT→HOLD edge.
- Reset asserted mid-operation aborts it:
  - The result is lost and `out_valid` drops immediately.
  - After reset release, `last_id` = 1 again.
- `out_ready` high while `out_valid` = 0 has no effect.

## Test plan
- Reset checks:
  - Assert `rst` with all requests low: all outputs at reset values.
  - Release reset: state stays IDLE and no `gnt` is issued.
- Single left shift: `req0` with in0 = 8'hB3, shamt0 = 3, dir0 = 1, `out_ready` = 1.
  - `gnt0` 1 cycle after sampling.
  - `out_valid` the following cycle with `out_data` = 8'h98, `out_id` = 0.
- Single right shift: `req1` with in1 = 8'hB3, shamt1 = 3, dir1 = 0.
  - `out_data` = 8'h16, `out_id` = 1.
  - shamt1 = 0 gives 8'hB3; shamt1 = 7 with dir1 = 0 gives 8'h01.
- Contention fairness: `req0` and `req1` held high continuously, re-asserted after each `gnt`.
  - Grants alternate 0,1,0,1 starting with 0.
  - `out_id` sequence matches the grant sequence.
- Backpressure: `out_ready` low for 5 cycles after `out_valid`.
  - `out_valid`, `out_data` and `out_id` stay stable.
  - A `req1` raised meanwhile gets no `gnt1` until 1 cycle after acceptance returns the FSM to IDLE.
- Reset mid-operation: assert `rst` during SHIFT, and separately during HOLD.
  - `out_valid` falls immediately and no `gnt` is issued.
  - After release, a contention grants requester 0 first.
